dpe_vec_loader: RTL and testbench
=================================

// Module: dpe_vec_loader
// PURPOSE
//  Producer-side front end for the pipelined CSA reduction tree. Accepts a stream of
//  WIDTH-bit elements, one per cycle, over a valid/ready handshake. Packs them into
//  INPUT_VEC_LEN-element vectors in a ping-pong pair of buffers. Presents each complete
//  (or early-terminated, zero-padded) vector as the packed `in` operand of the adder,
//  with its own valid/ready handshake.
// PARAMETERS
//  INPUT_VEC_LEN  8   elements per vector (>=2); index width CW = $clog2(INPUT_VEC_LEN+1)
//  WIDTH          16  bits per element
// PORTS
//  clk        in   1                      clock; all state updates on posedge
//  rst_n      in   1                      asynchronous reset, active-low
//  in_data    in   WIDTH                  element value
//  in_valid   in   1                      in_data/in_last valid this cycle
//  in_last    in   1                      element closes the current vector early
//  in_ready   out  1                      loader can accept an element this cycle
//  out_vec    out  INPUT_VEC_LEN*WIDTH    packed vector [INPUT_VEC_LEN-1:0][WIDTH-1:0]; element 0 first received
//  out_cnt    out  CW                     number of real (non-pad) elements in out_vec, 1..INPUT_VEC_LEN
//  out_valid  out  1                      out_vec/out_cnt hold a complete vector
//  out_ready  in   1                      consumer (CSA tree) takes the vector this cycle
// BEHAVIOUR
//  Storage
//   - Two buffers B0/B1, each INPUT_VEC_LEN x WIDTH, plus count and full flag.
//   - wr_sel selects the buffer being filled; rd_sel selects the buffer being presented.
//   - Fill index idx runs 0..INPUT_VEC_LEN-1.
//  Reset (rst_n=0, asynchronous)
//   - Clears both buffers to 0 and both full flags; sets wr_sel=rd_sel=0, idx=0.
//   - Output values during and after reset: out_valid=0, out_vec=0, out_cnt=0, in_ready=1.
//   - Reset mid-operation discards all partial and complete vectors, with no output glitch.
//  Input side
//   - in_ready = !full[wr_sel], combinational from registered state only (no in_valid path).
//   - Accept = in_valid && in_ready: write B[wr_sel][idx] <= in_data, then idx++.
//   - Closing accept (idx==INPUT_VEC_LEN-1, or in_last=1):
//       count[wr_sel] <= idx+1; full[wr_sel] <= 1; wr_sel toggles; idx <= 0.
//   - in_last=1 with idx==0 closes a 1-element vector.
//   - in_last on the final slot behaves the same as a normal close.
//   - in_valid while in_ready=0: element not taken; the source must hold it.
//  Output side
//   - out_valid = full[rd_sel]; out_vec = B[rd_sel]; out_cnt = count[rd_sel]; all registered.
//   - Latency: a vector closed at edge t shows out_valid=1 after edge t (visible in cycle t+1).
//   - Release = out_valid && out_ready: full[rd_sel] <= 0, B[rd_sel] <= 0, count <= 0, rd_sel toggles.
//   - Padding: B[rd_sel] is zeroed on release, so unwritten slots of an early-closed vector read 0.
//   - out_vec/out_cnt are stable while out_valid=1 and out_ready=0.
//  Boundary conditions
//   - Both buffers full: in_ready=0; out_valid stays 1 until release.
//   - Simultaneous close (input) and release (output) on the same edge:
//       both take effect; buffers always differ when both are full.
//       Throughput is 1 element/cycle with no bubbles when out_ready=1 continuously.
//   - Release of B[x] on the same edge that B[x] starts filling cannot occur, because wr_sel
//     only points at a non-full buffer.
//   - Zeroing never clobbers an accepted element.
//   - Element values pass through unmodified; no arithmetic or truncation.
// TESTING
//  T1 Reset:
//     rst_n=0 for 5 cycles with random inputs -> out_valid=0, out_vec=0, out_cnt=0, in_ready=1.
//  T2 Full vector:
//     8 elements 1..8 back-to-back, out_ready=1 -> one cycle after 8th accept:
//     out_valid=1, out_vec[j]=j+1, out_cnt=8. CSA sum = 36.
//  T3 Early close:
//     3 elements 5,6,7 with in_last on 7 -> out_cnt=3, out_vec={0,0,0,0,0,7,6,5}. Sum = 18.
//     Next vector starts at slot 0.
//  T4 Backpressure:
//     out_ready=0, stream 20 elements -> exactly 16 accepted, then in_ready=0.
//     Raise out_ready -> two vectors in order (1..8, 9..16), then remaining 4 accepted.
//  T5 Streaming:
//     out_ready=1, 50 random 8-element vectors at 1 element/cycle -> in_ready never drops.
//     Each out_vec sum equals the reference model sum (mod 2^WIDTH).
//  T6 Mid-op reset:
//     assert rst_n after 5 of 8 elements with one full vector pending -> both discarded;
//     next vector after reset emerges intact with out_cnt=8.

Source files
------------

// File: rtl/dpe_vec_loader.sv
// dpe_vec_loader: packs a one-element-per-cycle input stream into fixed-length
// vectors held in a ping-pong pair of buffers and presents each finished vector
// (zero-padded when closed early) to the CSA reduction tree.
module dpe_vec_loader #(
  parameter int INPUT_VEC_LEN = 8,
  parameter int WIDTH         = 16,
  localparam int CW           = $clog2(INPUT_VEC_LEN + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [INPUT_VEC_LEN*WIDTH-1:0] out_vec,
  output logic [CW-1:0]                  out_cnt,
  output logic                           out_valid,
  input  logic                           out_ready
);

  // Fill index only needs to address the slots of one buffer.
  localparam int IW = $clog2(INPUT_VEC_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(INPUT_VEC_LEN - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Buffer storage: [buffer][slot][bits]
  logic [1:0][INPUT_VEC_LEN-1:0][WIDTH-1:0] vbuf_q, vbuf_d;
  logic [1:0][CW-1:0]                       cnt_q, cnt_d;
  logic [1:0]                               full_q, full_d;
  logic                                     wr_sel_q, wr_sel_d;
  logic                                     rd_sel_q, rd_sel_d;
  logic [IW-1:0]                            idx_q, idx_d;

  // Registered copies of everything the outside world sees
  logic [INPUT_VEC_LEN*WIDTH-1:0]           out_vec_q;
  logic [CW-1:0]                            out_cnt_q;
  logic                                     out_valid_q;
  logic                                     in_ready_q;

  logic                                     accept_s;
  logic                                     close_s;
  logic                                     release_s;

  // in_ready_q always mirrors !full_q[wr_sel_q], so it never depends on in_valid.
  assign accept_s  = in_valid && in_ready_q;
  assign close_s   = accept_s && (in_last || (idx_q == LAST_IDX));
  assign release_s = out_valid_q && out_ready;

  // Next-state: release clears the presented buffer, accept writes the filling one.
  // Both may act on the same edge; they always target different buffers because a
  // release needs full[rd_sel] while an accept needs !full[wr_sel].
  always_comb begin
    vbuf_d   = vbuf_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;

    if (release_s) begin
      // Zeroing here is what provides the padding of the next early-closed vector.
      vbuf_d[rd_sel_q] = '0;
      cnt_d[rd_sel_q]  = '0;
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end else begin
      rd_sel_d = rd_sel_q;
    end

    if (accept_s) begin
      vbuf_d[wr_sel_q][idx_q] = in_data;
      if (close_s) begin
        cnt_d[wr_sel_q]  = CW'(idx_q) + CNT_ONE;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
        idx_d            = '0;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Buffer, count, flag and pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vbuf_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      vbuf_q   <= vbuf_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
    end
  end

  // Output registers loaded from next-state so they track the buffers with no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_vec_q   <= vbuf_d[rd_sel_d];
      out_cnt_q   <= cnt_d[rd_sel_d];
      out_valid_q <= full_d[rd_sel_d];
      in_ready_q  <= ~full_d[wr_sel_d];
    end
  end

  assign out_vec   = out_vec_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_dpe_vec_loader.sv
// Directed self-checking bench for dpe_vec_loader (INPUT_VEC_LEN=8, WIDTH=16).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_dpe_vec_loader;
  localparam int N  = 8;
  localparam int W  = 16;
  localparam int CW = 4;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [VW-1:0] out_vec;
  logic [CW-1:0] out_cnt;
  logic          out_valid;
  logic          out_ready;

  dpe_vec_loader #(.INPUT_VEC_LEN(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_vec(out_vec), .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] vsum(input logic [VW-1:0] v);
    logic [W-1:0] s;
    s = '0;
    for (int j = 0; j < N; j++) s = s + v[j*W +: W];
    return s;
  endfunction

  // Output monitor: records every vector handed to the consumer
  logic          mon_en = 1'b0;
  logic [VW-1:0] got_vec[$];
  logic [CW-1:0] got_cnt[$];
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_vec.push_back(out_vec);
      got_cnt.push_back(out_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one element (call at posedge+1); returns at posedge+1 of the accept edge.
  task automatic push(input logic [W-1:0] d, input logic l, output int stalls);
    logic rdy;
    rdy = 1'b0;
    stalls = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
    end
    if (!rdy) check("push_timeout", VW'(rdy), VW'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [VW-1:0] ev;
  logic [VW-1:0] exp_vec[$];
  logic [W-1:0]  exp_sum[$];
  logic [W-1:0]  e;
  int st, tot_st, acc;

  initial begin
    // T1: reset with random inputs
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom); in_last = 1'($urandom); in_data = W'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check("t1_valid", VW'(out_valid), VW'(0));
      check("t1_vec", out_vec, '0);
      check("t1_cnt", VW'(out_cnt), VW'(0));
      check("t1_ready", VW'(in_ready), VW'(1));
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // T2: full vector 1..8, visible the cycle after the 8th accept
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) push(W'(j + 1), 1'b0, st);
    @(negedge clk);
    ev = '0;
    for (int j = 0; j < N; j++) ev[j*W +: W] = W'(j + 1);
    check("t2_valid", VW'(out_valid), VW'(1));
    check("t2_vec", out_vec, ev);
    check("t2_cnt", VW'(out_cnt), VW'(8));
    check("t2_sum", VW'(vsum(out_vec)), VW'(36));
    step();
    check("t2_released", VW'(out_valid), VW'(0));

    // T3: early close 5,6,7 then a 1-element vector starting at slot 0
    push(16'd5, 1'b0, st); push(16'd6, 1'b0, st); push(16'd7, 1'b1, st);
    @(negedge clk);
    ev = '0; ev[0*W +: W] = 16'd5; ev[1*W +: W] = 16'd6; ev[2*W +: W] = 16'd7;
    check("t3_valid", VW'(out_valid), VW'(1));
    check("t3_vec", out_vec, ev);
    check("t3_cnt", VW'(out_cnt), VW'(3));
    check("t3_sum", VW'(vsum(out_vec)), VW'(18));
    step();
    push(16'd9, 1'b1, st);
    @(negedge clk);
    ev = '0; ev[0*W +: W] = 16'd9;
    check("t3_one_vec", out_vec, ev);
    check("t3_one_cnt", VW'(out_cnt), VW'(1));
    step();

    // T4: backpressure, exactly 16 accepted while the consumer stalls
    out_ready = 1'b0;
    step();
    acc = 0; in_valid = 1'b1; in_last = 1'b0; in_data = 16'd1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      e[0] = in_ready;
      @(posedge clk); #1;
      if (e[0]) begin acc++; in_data = W'(acc + 1); end
    end
    check("t4_acc16", VW'(acc), VW'(16));
    @(negedge clk);
    ev = '0;
    for (int j = 0; j < N; j++) ev[j*W +: W] = W'(j + 1);
    check("t4_stall_ready", VW'(in_ready), VW'(0));
    check("t4_stall_valid", VW'(out_valid), VW'(1));
    check("t4_stall_vec", out_vec, ev);
    step();
    got_vec.delete(); got_cnt.delete();
    mon_en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 20; c++) begin
      @(negedge clk);
      e[0] = in_ready;
      @(posedge clk); #1;
      if (e[0]) begin acc++; in_data = W'(acc + 1); end
    end
    in_valid = 1'b0;
    check("t4_acc20", VW'(acc), VW'(20));
    push(16'd21, 1'b1, st);
    repeat (3) step();
    check("t4_nvec", VW'(got_vec.size()), VW'(3));
    if (got_vec.size() == 3) begin
      for (int v = 0; v < 2; v++) begin
        ev = '0;
        for (int j = 0; j < N; j++) ev[j*W +: W] = W'(v * N + j + 1);
        check("t4_order_vec", got_vec[v], ev);
        check("t4_order_cnt", VW'(got_cnt[v]), VW'(8));
      end
      ev = '0;
      for (int j = 0; j < 5; j++) ev[j*W +: W] = W'(17 + j);
      check("t4_tail_vec", got_vec[2], ev);
      check("t4_tail_cnt", VW'(got_cnt[2]), VW'(5));
    end

    // T5: streaming 50 random vectors, no input stalls allowed
    got_vec.delete(); got_cnt.delete();
    tot_st = 0;
    for (int v = 0; v < 50; v++) begin
      ev = '0;
      for (int j = 0; j < N; j++) begin
        e = W'($urandom);
        ev[j*W +: W] = e;
        push(e, 1'b0, st);
        tot_st += st;
      end
      exp_vec.push_back(ev);
      exp_sum.push_back(vsum(ev));
    end
    repeat (3) step();
    check("t5_stalls", VW'(tot_st), VW'(0));
    check("t5_nvec", VW'(got_vec.size()), VW'(50));
    for (int v = 0; v < 50 && v < got_vec.size(); v++) begin
      check("t5_sum", VW'(vsum(got_vec[v])), VW'(exp_sum[v]));
      check("t5_vec", got_vec[v], exp_vec[v]);
    end

    // T6: reset mid-operation discards pending and partial vectors
    mon_en = 1'b0; out_ready = 1'b0;
    step();
    for (int j = 0; j < N; j++) push(W'(40 + j), 1'b0, st);
    for (int j = 0; j < 5; j++) push(W'(60 + j), 1'b0, st);
    @(negedge clk);
    check("t6_pending", VW'(out_valid), VW'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", VW'(out_valid), VW'(0));
    check("t6_rst_vec", out_vec, '0);
    check("t6_rst_cnt", VW'(out_cnt), VW'(0));
    check("t6_rst_ready", VW'(in_ready), VW'(1));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    got_vec.delete(); got_cnt.delete();
    mon_en = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < N; j++) push(W'(100 + j), 1'b0, st);
    repeat (3) step();
    check("t6_nvec", VW'(got_vec.size()), VW'(1));
    if (got_vec.size() >= 1) begin
      ev = '0;
      for (int j = 0; j < N; j++) ev[j*W +: W] = W'(100 + j);
      check("t6_vec", got_vec[0], ev);
      check("t6_cnt", VW'(got_cnt[0]), VW'(8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
